// File: rtl/mips_pkg.sv
// Shared MIPS encodings plus the multi-cycle controller's state, class and select codes.
package mips_pkg;

    localparam int REG_WR_ADDR_WIDTH = 2;
    localparam int ALU_SRC_WIDTH     = 2;
    localparam int ALU_CTRL_WIDTH    = 4;
    localparam int REG_WR_SRC_WIDTH  = 3;
    localparam int HI_LO_SEL_WIDTH   = 2;

    typedef enum logic [5:0] {
        OP_RTYPE    = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
        OP_BEQ      = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
        OP_ADDI     = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
        OP_ANDI     = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
        OP_SPECIAL2 = 6'h1C, OP_LB     = 6'h20, OP_LH    = 6'h21, OP_LW    = 6'h23,
        OP_LBU      = 6'h24, OP_LHU    = 6'h25, OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL  = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03, F_JR    = 6'h08,
        F_JALR = 6'h09, F_MFHI  = 6'h10, F_MTHI = 6'h11, F_MFLO  = 6'h12,
        F_MTLO = 6'h13, F_MULT  = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A,
        F_DIVU = 6'h1B, F_ADD   = 6'h20, F_ADDU = 6'h21, F_SUB   = 6'h22,
        F_SUBU = 6'h23, F_AND   = 6'h24, F_OR   = 6'h25, F_XOR   = 6'h26,
        F_NOR  = 6'h27, F_SLT   = 6'h2A, F_SLTU = 6'h2B
    } funct_t;

    // SPECIAL2 MUL shares its funct value with SRL, so it lives outside funct_t.
    localparam logic [5:0] FN2_MUL = 6'h02;

    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
        WB = 3'd4, MD_WAIT = 3'd5, EXCEPT = 3'd6
    } ctrl_state_t;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_ALU, CLS_BRANCH, CLS_JUMP, CLS_LOAD, CLS_STORE,
        CLS_MFHILO, CLS_MTHI, CLS_MTLO, CLS_MULDIV
    } instr_class_t;

    typedef enum logic [2:0] {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LE, BR_GT} br_cond_t;

    localparam logic [1:0] PCSRC_PC4    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    localparam logic [HI_LO_SEL_WIDTH-1:0] HILO_SEL_RS   = 2'b01;
    localparam logic [HI_LO_SEL_WIDTH-1:0] HILO_SEL_DIV  = 2'b10;
    localparam logic [HI_LO_SEL_WIDTH-1:0] HILO_SEL_MULT = 2'b11;

    localparam logic [REG_WR_ADDR_WIDTH-1:0] REGDST_RT = 2'b00;
    localparam logic [REG_WR_ADDR_WIDTH-1:0] REGDST_RD = 2'b01;
    localparam logic [REG_WR_ADDR_WIDTH-1:0] REGDST_RA = 2'b10;

    localparam logic [ALU_SRC_WIDTH-1:0] SRC_REG   = 2'b00;
    localparam logic [ALU_SRC_WIDTH-1:0] SRC_SEXT  = 2'b01;
    localparam logic [ALU_SRC_WIDTH-1:0] SRC_ZEXT  = 2'b10;
    localparam logic [ALU_SRC_WIDTH-1:0] SRC_SHAMT = 2'b11;

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2,
        ALU_OR = 4'h3, ALU_XOR = 4'h4, ALU_NOR = 4'h5, ALU_SLT = 4'h6, ALU_SLTU = 4'h7,
        ALU_SLL = 4'h8, ALU_SRL = 4'h9, ALU_SRA = 4'hA, ALU_LUI = 4'hB;

    localparam logic [REG_WR_SRC_WIDTH-1:0] WB_ALU = 3'b000, WB_MEM = 3'b001, WB_HI = 3'b010,
        WB_LO = 3'b011, WB_PC4 = 3'b100, WB_MUL = 3'b110;

    typedef struct packed {
        instr_class_t                  cls;
        logic                          illegal;
        logic                          ov_check;
        logic                          md_div;
        logic                          md_unsigned;
        logic                          md_to_rd;
        logic                          link;
        logic [1:0]                    pcsrc;
        br_cond_t                      br_cond;
        logic [ALU_SRC_WIDTH-1:0]      alusrc;
        logic [ALU_CTRL_WIDTH-1:0]     aluctrl;
        logic [REG_WR_ADDR_WIDTH-1:0]  regdst;
        logic [REG_WR_SRC_WIDTH-1:0]   wb_sel;
    } decode_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure combinational instruction classifier: class, ALU fields and write-back routing.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [4:0] rt,
    input  logic [5:0] funct,
    output decode_t    dec
);

    always_comb begin
        dec = '0;
        dec.cls = CLS_NOP;
        dec.br_cond = BR_EQ;
        case (opcode)
            OP_RTYPE: begin
                dec.cls    = CLS_ALU;
                dec.regdst = REGDST_RD;
                case (funct)
                    F_SLL:   begin dec.aluctrl = ALU_SLL; dec.alusrc = SRC_SHAMT; end
                    F_SRL:   begin dec.aluctrl = ALU_SRL; dec.alusrc = SRC_SHAMT; end
                    F_SRA:   begin dec.aluctrl = ALU_SRA; dec.alusrc = SRC_SHAMT; end
                    F_JR:    begin dec.cls = CLS_JUMP; dec.pcsrc = PCSRC_REG; end
                    F_JALR:  begin
                        dec.cls = CLS_JUMP; dec.pcsrc = PCSRC_REG;
                        dec.link = 1'b1; dec.wb_sel = WB_PC4;
                    end
                    F_MFHI:  begin dec.cls = CLS_MFHILO; dec.wb_sel = WB_HI; end
                    F_MFLO:  begin dec.cls = CLS_MFHILO; dec.wb_sel = WB_LO; end
                    F_MTHI:  dec.cls = CLS_MTHI;
                    F_MTLO:  dec.cls = CLS_MTLO;
                    F_MULT:  dec.cls = CLS_MULDIV;
                    F_MULTU: begin dec.cls = CLS_MULDIV; dec.md_unsigned = 1'b1; end
                    F_DIV:   begin dec.cls = CLS_MULDIV; dec.md_div = 1'b1; end
                    F_DIVU:  begin
                        dec.cls = CLS_MULDIV; dec.md_div = 1'b1; dec.md_unsigned = 1'b1;
                    end
                    F_ADD:   begin dec.aluctrl = ALU_ADD; dec.ov_check = 1'b1; end
                    F_ADDU:  dec.aluctrl = ALU_ADD;
                    F_SUB:   begin dec.aluctrl = ALU_SUB; dec.ov_check = 1'b1; end
                    F_SUBU:  dec.aluctrl = ALU_SUB;
                    F_AND:   dec.aluctrl = ALU_AND;
                    F_OR:    dec.aluctrl = ALU_OR;
                    F_XOR:   dec.aluctrl = ALU_XOR;
                    F_NOR:   dec.aluctrl = ALU_NOR;
                    F_SLT:   dec.aluctrl = ALU_SLT;
                    F_SLTU:  dec.aluctrl = ALU_SLTU;
                    default: begin dec.cls = CLS_NOP; dec.illegal = 1'b1; end
                endcase
            end
            OP_REGIMM: begin
                // Branch compares rs against zero; the ALU's neg/zero flags decide.
                dec.cls = CLS_BRANCH; dec.aluctrl = ALU_SUB;
                if (rt == 5'd0)      dec.br_cond = BR_LT;
                else if (rt == 5'd1) dec.br_cond = BR_GE;
                else begin dec.cls = CLS_NOP; dec.illegal = 1'b1; end
            end
            OP_J:    begin dec.cls = CLS_JUMP; dec.pcsrc = PCSRC_JUMP; end
            OP_JAL:  begin
                dec.cls = CLS_JUMP; dec.pcsrc = PCSRC_JUMP; dec.link = 1'b1;
                dec.regdst = REGDST_RA; dec.wb_sel = WB_PC4;
            end
            OP_BEQ:  begin dec.cls = CLS_BRANCH; dec.aluctrl = ALU_SUB; dec.br_cond = BR_EQ; end
            OP_BNE:  begin dec.cls = CLS_BRANCH; dec.aluctrl = ALU_SUB; dec.br_cond = BR_NE; end
            OP_BLEZ: begin dec.cls = CLS_BRANCH; dec.aluctrl = ALU_SUB; dec.br_cond = BR_LE; end
            OP_BGTZ: begin dec.cls = CLS_BRANCH; dec.aluctrl = ALU_SUB; dec.br_cond = BR_GT; end
            OP_ADDI: begin
                dec.cls = CLS_ALU; dec.aluctrl = ALU_ADD; dec.alusrc = SRC_SEXT; dec.ov_check = 1'b1;
            end
            OP_ADDIU: begin dec.cls = CLS_ALU; dec.aluctrl = ALU_ADD;  dec.alusrc = SRC_SEXT; end
            OP_SLTI:  begin dec.cls = CLS_ALU; dec.aluctrl = ALU_SLT;  dec.alusrc = SRC_SEXT; end
            OP_SLTIU: begin dec.cls = CLS_ALU; dec.aluctrl = ALU_SLTU; dec.alusrc = SRC_SEXT; end
            OP_ANDI:  begin dec.cls = CLS_ALU; dec.aluctrl = ALU_AND;  dec.alusrc = SRC_ZEXT; end
            OP_ORI:   begin dec.cls = CLS_ALU; dec.aluctrl = ALU_OR;   dec.alusrc = SRC_ZEXT; end
            OP_XORI:  begin dec.cls = CLS_ALU; dec.aluctrl = ALU_XOR;  dec.alusrc = SRC_ZEXT; end
            OP_LUI:   begin dec.cls = CLS_ALU; dec.aluctrl = ALU_LUI;  dec.alusrc = SRC_ZEXT; end
            OP_SPECIAL2: begin
                if (funct == FN2_MUL) begin
                    dec.cls = CLS_MULDIV; dec.md_to_rd = 1'b1;
                    dec.regdst = REGDST_RD; dec.wb_sel = WB_MUL;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                dec.cls = CLS_LOAD; dec.aluctrl = ALU_ADD; dec.alusrc = SRC_SEXT; dec.wb_sel = WB_MEM;
            end
            OP_SW: begin dec.cls = CLS_STORE; dec.aluctrl = ALU_ADD; dec.alusrc = SRC_SEXT; end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM with memory wait, mul/div stall and precise exceptions.
// Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap undefined instructions instead of retiring them as NOPs.
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [INSTR_WIDTH-1:0]       instr,
    input  logic [2:0]                   alu_flags,
    input  logic                         mem_ready,
    output logic                         mem_req,
    output logic                         iord,
    output logic                         memwrite,
    output logic                         irwrite,
    output logic                         pcwrite,
    output logic [1:0]                   pcsrc,
    output logic                         exc_redirect,
    output logic                         regwrite,
    output logic [REG_WR_ADDR_WIDTH-1:0] regdst,
    output logic [ALU_SRC_WIDTH-1:0]     alusrc,
    output logic [ALU_CTRL_WIDTH-1:0]    alucontrl,
    output logic [REG_WR_SRC_WIDTH-1:0]  write_back_sel,
    output logic                         muldiv_start,
    output logic                         unsigned_md,
    output logic                         hi_write,
    output logic                         lo_write,
    output logic [HI_LO_SEL_WIDTH-1:0]   hilo_select,
    output logic                         arth_overflow_exception,
    output logic                         illegal_instr_exception,
    output logic [2:0]                   ctrl_state
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W  = $clog2(MD_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    ctrl_state_t      state;
    logic [CNT_W-1:0] count;
    logic             exc_illegal;
    logic             br_taken;
    decode_t          dec;
    logic             unused_instr;

    assign unused_instr = ^{instr[25:21], instr[15:6]};

    mips_ctrl_decode u_decode (
        .opcode (instr[31:26]),
        .rt     (instr[20:16]),
        .funct  (instr[5:0]),
        .dec    (dec)
    );

    // alu_flags = {overflow, neg, zero}, from rs - rt (or rs - 0) in EXEC.
    always_comb begin
        case (dec.br_cond)
            BR_EQ:   br_taken = alu_flags[0];
            BR_NE:   br_taken = !alu_flags[0];
            BR_LT:   br_taken = alu_flags[1];
            BR_GE:   br_taken = !alu_flags[1];
            BR_LE:   br_taken = alu_flags[1] | alu_flags[0];
            BR_GT:   br_taken = !alu_flags[1] & !alu_flags[0];
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            count       <= '0;
            exc_illegal <= 1'b0;
        end else begin
            case (state)
                FETCH:  if (mem_ready) state <= DECODE;
                DECODE: begin
                    if (dec.illegal) begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                        state       <= EXCEPT;
                        exc_illegal <= 1'b1;
`else
                        state <= FETCH;
`endif
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (dec.cls)
                        CLS_ALU: begin
                            if (dec.ov_check && alu_flags[2]) begin
                                state       <= EXCEPT;
                                exc_illegal <= 1'b0;
                            end else begin
                                state <= WB;
                            end
                        end
                        CLS_LOAD, CLS_STORE: state <= MEM;
                        CLS_MULDIV: begin
                            state <= MD_WAIT;
                            count <= dec.md_div ? DIV_LOAD : MULT_LOAD;
                        end
                        default: state <= FETCH;
                    endcase
                end
                MEM:     if (mem_ready) state <= (dec.cls == CLS_LOAD) ? WB : FETCH;
                MD_WAIT: begin
                    if (count == '0) state <= FETCH;
                    else             count <= count - 1'b1;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Every output is forced low while rst_n is asserted, even though state reads FETCH.
    always_comb begin
        mem_req = 1'b0; iord = 1'b0; memwrite = 1'b0; irwrite = 1'b0;
        pcwrite = 1'b0; pcsrc = PCSRC_PC4; exc_redirect = 1'b0; regwrite = 1'b0;
        regdst = REGDST_RT; alusrc = SRC_REG; alucontrl = ALU_ADD; write_back_sel = WB_ALU;
        muldiv_start = 1'b0; unsigned_md = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        hilo_select = '0; arth_overflow_exception = 1'b0; illegal_instr_exception = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        irwrite = 1'b1;
                        pcwrite = 1'b1;
                    end
                end
                EXEC: begin
                    alusrc    = dec.alusrc;
                    alucontrl = dec.aluctrl;
                    case (dec.cls)
                        CLS_BRANCH: begin pcwrite = br_taken; pcsrc = PCSRC_BRANCH; end
                        CLS_JUMP: begin
                            pcwrite = 1'b1;
                            pcsrc   = dec.pcsrc;
                            if (dec.link) begin
                                regwrite       = 1'b1;
                                regdst         = dec.regdst;
                                write_back_sel = dec.wb_sel;
                            end
                        end
                        CLS_MFHILO: begin
                            regwrite = 1'b1; regdst = dec.regdst; write_back_sel = dec.wb_sel;
                        end
                        CLS_MTHI:   begin hi_write = 1'b1; hilo_select = HILO_SEL_RS; end
                        CLS_MTLO:   begin lo_write = 1'b1; hilo_select = HILO_SEL_RS; end
                        CLS_MULDIV: begin muldiv_start = 1'b1; unsigned_md = dec.md_unsigned; end
                        default: ;
                    endcase
                end
                MEM: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = (dec.cls == CLS_STORE);
                end
                WB: begin
                    regwrite = 1'b1; regdst = dec.regdst; write_back_sel = dec.wb_sel;
                    alusrc = dec.alusrc; alucontrl = dec.aluctrl;
                end
                MD_WAIT: begin
                    if (count == '0) begin
                        if (dec.md_to_rd) begin
                            regwrite = 1'b1; regdst = dec.regdst; write_back_sel = dec.wb_sel;
                        end else begin
                            hi_write    = 1'b1;
                            lo_write    = 1'b1;
                            hilo_select = dec.md_div ? HILO_SEL_DIV : HILO_SEL_MULT;
                        end
                    end
                end
                EXCEPT: begin
                    exc_redirect            = 1'b1;
                    pcwrite                 = 1'b1;
                    arth_overflow_exception = !exc_illegal;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                    illegal_instr_exception = exc_illegal;
`endif
                end
                default: ;
            endcase
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller with immediate-assertion checks.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [31:0] instr;
    logic [2:0] alu_flags;
    logic       mem_ready;
    logic       mem_req, iord, memwrite, irwrite, pcwrite, exc_redirect, regwrite;
    logic [1:0] pcsrc, regdst, alusrc, hilo_select;
    logic [3:0] alucontrl;
    logic [2:0] write_back_sel, ctrl_state;
    logic       muldiv_start, unsigned_md, hi_write, lo_write;
    logic       arth_overflow_exception, illegal_instr_exception;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                           S_WB = 3'd4, S_MDWAIT = 3'd5, S_EXCEPT = 3'd6;

    localparam logic [31:0] I_ADD = 32'h0022_1820;  // add  $3,$1,$2
    localparam logic [31:0] I_LW  = 32'h8C22_0004;  // lw   $2,4($1)
    localparam logic [31:0] I_SW  = 32'hAC22_0004;  // sw   $2,4($1)
    localparam logic [31:0] I_DIV = 32'h0022_001A;  // div  $1,$2
    localparam logic [31:0] I_MUL = 32'h7022_1802;  // mul  $3,$1,$2
    localparam logic [31:0] I_BEQ = 32'h1022_0004;  // beq  $1,$2,4
    localparam logic [31:0] I_JAL = 32'h0C00_0010;  // jal  0x40
    localparam logic [31:0] I_BAD = 32'hFC00_0000;  // opcode 0x3F

    mips_mc_controller #(.INSTR_WIDTH(32), .MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .alu_flags(alu_flags), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .pcsrc(pcsrc), .exc_redirect(exc_redirect), .regwrite(regwrite),
        .regdst(regdst), .alusrc(alusrc), .alucontrl(alucontrl), .write_back_sel(write_back_sel),
        .muldiv_start(muldiv_start), .unsigned_md(unsigned_md), .hi_write(hi_write),
        .lo_write(lo_write), .hilo_select(hilo_select),
        .arth_overflow_exception(arth_overflow_exception),
        .illegal_instr_exception(illegal_instr_exception), .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts in FETCH, stalls one cycle, completes the fetch and leaves the DUT in DECODE.
    task automatic fetch_decode(input logic [31:0] iv);
        chk("fetch_state", {29'd0, ctrl_state}, {29'd0, S_FETCH});
        mem_ready = 1'b0;
        #1;
        chk("fetch_memreq", {31'd0, mem_req}, 32'd1);
        chk("fetch_stall_irwrite", {31'd0, irwrite}, 32'd0);
        tick;
        chk("fetch_hold_state", {29'd0, ctrl_state}, {29'd0, S_FETCH});
        mem_ready = 1'b1;
        #1;
        chk("fetch_irwrite", {31'd0, irwrite}, 32'd1);
        chk("fetch_pcwrite", {31'd0, pcwrite}, 32'd1);
        chk("fetch_pcsrc", {30'd0, pcsrc}, 32'd0);
        chk("fetch_iord", {31'd0, iord}, 32'd0);
        tick;
        mem_ready = 1'b0;
        instr     = iv;
        #1;
        chk("decode_state", {29'd0, ctrl_state}, {29'd0, S_DECODE});
        chk("decode_strobes", {28'd0, pcwrite, regwrite, mem_req, muldiv_start}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; instr = 32'd0; alu_flags = 3'b000; mem_ready = 1'b0;
        #3;
        chk("rst_state", {29'd0, ctrl_state}, {29'd0, S_FETCH});
        chk("rst_outputs", {26'd0, mem_req, irwrite, pcwrite, regwrite, hi_write, exc_redirect}, 32'd0);
        #20;
        rst_n = 1'b1;
        tick;

        // ADD overflow: no regwrite in EXEC, EXCEPT next cycle
        fetch_decode(I_ADD);
        tick;
        alu_flags = 3'b100;
        #1;
        chk("add_exec_state", {29'd0, ctrl_state}, {29'd0, S_EXEC});
        chk("add_exec_alu", {28'd0, alucontrl}, 32'h0);
        chk("add_exec_alusrc", {30'd0, alusrc}, 32'h0);
        chk("add_ov_regwrite", {31'd0, regwrite}, 32'd0);
        tick;
        alu_flags = 3'b000;
        #1;
        chk("add_except_state", {29'd0, ctrl_state}, {29'd0, S_EXCEPT});
        chk("add_except_redirect", {31'd0, exc_redirect}, 32'd1);
        chk("add_except_pcwrite", {31'd0, pcwrite}, 32'd1);
        chk("add_except_ovpulse", {31'd0, arth_overflow_exception}, 32'd1);
        chk("add_except_illegal", {31'd0, illegal_instr_exception}, 32'd0);
        chk("add_except_regwrite", {31'd0, regwrite}, 32'd0);
        tick;
        chk("add_after_except", {30'd0, ctrl_state[2:1]}, 32'd0);
        chk("add_ovpulse_gone", {31'd0, arth_overflow_exception}, 32'd0);

        // ADD without overflow writes rd from the ALU in WB
        fetch_decode(I_ADD);
        tick;
        tick;
        chk("add_wb_state", {29'd0, ctrl_state}, {29'd0, S_WB});
        chk("add_wb_regwrite", {31'd0, regwrite}, 32'd1);
        chk("add_wb_regdst", {30'd0, regdst}, 32'd1);
        chk("add_wb_sel", {29'd0, write_back_sel}, 32'd0);
        tick;

        // LW with three wait cycles in MEM
        fetch_decode(I_LW);
        tick;
        chk("lw_exec_alusrc", {30'd0, alusrc}, 32'd1);
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_state", {29'd0, ctrl_state}, {29'd0, S_MEM});
            chk("lw_mem_req_iord", {30'd0, mem_req, iord}, 32'd3);
            chk("lw_mem_memwrite", {31'd0, memwrite}, 32'd0);
            tick;
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_mem_ready_req", {30'd0, mem_req, iord}, 32'd3);
        chk("lw_mem_no_regwrite", {31'd0, regwrite}, 32'd0);
        tick;
        mem_ready = 1'b0;
        #1;
        chk("lw_wb_state", {29'd0, ctrl_state}, {29'd0, S_WB});
        chk("lw_wb_regwrite", {31'd0, regwrite}, 32'd1);
        chk("lw_wb_regdst", {30'd0, regdst}, 32'd0);
        chk("lw_wb_sel", {29'd0, write_back_sel}, 32'd1);
        tick;
        chk("lw_done_regwrite", {31'd0, regwrite}, 32'd0);

        // SW: memwrite with the request, straight back to FETCH
        fetch_decode(I_SW);
        tick;
        tick;
        mem_ready = 1'b1;
        #1;
        chk("sw_memwrite", {29'd0, mem_req, iord, memwrite}, 32'd7);
        tick;
        mem_ready = 1'b0;
        #1;
        chk("sw_to_fetch", {29'd0, ctrl_state}, {29'd0, S_FETCH});

        // DIV: start in EXEC, hi/lo strobes exactly 32 cycles later
        fetch_decode(I_DIV);
        tick;
        chk("div_start", {30'd0, muldiv_start, unsigned_md}, 32'd2);
        chk("div_exec_hilo", {30'd0, hi_write, lo_write}, 32'd0);
        for (int i = 1; i <= 32; i++) begin
            tick;
            chk("div_wait_state", {29'd0, ctrl_state}, {29'd0, S_MDWAIT});
            chk("div_hilo_strobe", {30'd0, hi_write, lo_write}, (i == 32) ? 32'd3 : 32'd0);
            chk("div_no_start", {31'd0, muldiv_start}, 32'd0);
        end
        chk("div_hilo_sel", {30'd0, hilo_select}, 32'd2);
        tick;
        chk("div_to_fetch", {29'd0, ctrl_state}, {29'd0, S_FETCH});
        chk("div_strobe_once", {30'd0, hi_write, lo_write}, 32'd0);

        // MUL: result to rd after 4 cycles, HI/LO untouched
        fetch_decode(I_MUL);
        tick;
        chk("mul_start", {31'd0, muldiv_start}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk("mul_regwrite", {31'd0, regwrite}, (i == 4) ? 32'd1 : 32'd0);
            chk("mul_no_hilo", {30'd0, hi_write, lo_write}, 32'd0);
        end
        chk("mul_wb_sel", {29'd0, write_back_sel}, 32'd6);
        chk("mul_regdst", {30'd0, regdst}, 32'd1);
        tick;

        // BEQ taken and not taken
        fetch_decode(I_BEQ);
        tick;
        alu_flags = 3'b001;
        #1;
        chk("beq_taken_pcwrite", {31'd0, pcwrite}, 32'd1);
        chk("beq_taken_pcsrc", {30'd0, pcsrc}, 32'd1);
        chk("beq_alu_sub", {28'd0, alucontrl}, 32'd1);
        tick;
        alu_flags = 3'b000;
        fetch_decode(I_BEQ);
        tick;
        chk("beq_nt_pcwrite", {31'd0, pcwrite}, 32'd0);
        tick;
        chk("beq_nt_next", {29'd0, ctrl_state}, {29'd0, S_FETCH});

        // JAL: jump plus link write to $ra
        fetch_decode(I_JAL);
        tick;
        chk("jal_pc", {29'd0, pcwrite, pcsrc}, 32'h6);
        chk("jal_link", {26'd0, regwrite, regdst, write_back_sel}, {26'd0, 1'b1, 2'b10, 3'b100});
        tick;

        // Undefined opcode 0x3F
        fetch_decode(I_BAD);
        tick;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        chk("bad_except_state", {29'd0, ctrl_state}, {29'd0, S_EXCEPT});
        chk("bad_illegal_pulse", {31'd0, illegal_instr_exception}, 32'd1);
        chk("bad_redirect", {30'd0, exc_redirect, arth_overflow_exception}, 32'd2);
        tick;
`else
        chk("bad_nop_state", {29'd0, ctrl_state}, {29'd0, S_FETCH});
        chk("bad_nop_strobes", {27'd0, irwrite, regwrite, exc_redirect, illegal_instr_exception, hi_write}, 32'd0);
`endif
        chk("bad_back_fetch", {29'd0, ctrl_state}, {29'd0, S_FETCH});

        // Reset during MD_WAIT abandons the divide
        fetch_decode(I_DIV);
        tick;
        tick;
        tick;
        tick;
        chk("rstmd_in_wait", {29'd0, ctrl_state}, {29'd0, S_MDWAIT});
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmd_state", {29'd0, ctrl_state}, {29'd0, S_FETCH});
        chk("rstmd_outputs", {28'd0, mem_req, hi_write, lo_write, regwrite}, 32'd0);
        for (int i = 0; i < 34; i++) begin
            tick;
            chk("rstmd_no_hilo", {30'd0, hi_write, lo_write}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("rstmd_release_state", {29'd0, ctrl_state}, {29'd0, S_FETCH});
        chk("rstmd_release_req", {30'd0, mem_req, iord}, 32'd2);
        mem_ready = 1'b1;
        #1;
        chk("rstmd_first_fetch", {31'd0, irwrite}, 32'd1);
        tick;
        mem_ready = 1'b0;
        #1;
        chk("rstmd_decode", {29'd0, ctrl_state}, {29'd0, S_DECODE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
